// File: rtl/matvec_sequencer.sv
// Time-multiplexed y = A*x controller (A is 3x4, x is 4x1, IEEE-754 single) that
// drives one shared FP multiplier and one shared FP adder from a writable coefficient bank.
module matvec_sequencer #(
  parameter int MUL_LAT = 1,
  parameter int ADD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [95:0]  out_y,
  input  logic         coef_we,
  input  logic [3:0]   coef_addr,
  input  logic [31:0]  coef_data,
  output logic         busy,
  output logic [31:0]  mul_a,
  output logic [31:0]  mul_b,
  input  logic [31:0]  mul_p,
  output logic [31:0]  add_a,
  output logic [31:0]  add_b,
  input  logic [31:0]  add_s
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] MUL_LAST = 8'(MUL_LAT - 1);
  localparam logic [7:0] ADD_LAST = 8'(ADD_LAT - 1);

  localparam logic [31:0] COEF_DEF [0:11] = '{
    32'h3f000000, 32'hbfc00000, 32'hbf400000, 32'hbf600000,
    32'h3f400000, 32'h3f000000, 32'hbf400000, 32'hbfa00000,
    32'h3f400000, 32'hbe000000, 32'h3fb00000, 32'h3e800000
  };

  state_t      state_r, state_nxt;
  logic [31:0] coef_r [0:11];
  logic [31:0] x_r    [0:3];
  logic [31:0] x_nxt  [0:3];
  logic [31:0] acc_r, acc_nxt;
  logic [31:0] y0_r, y0_nxt;
  logic [31:0] y1_r, y1_nxt;
  logic [1:0]  row_r, row_nxt;
  logic [1:0]  col_r, col_nxt;
  logic [7:0]  phase_r, phase_nxt;
  logic        in_ready_nxt, out_valid_nxt, busy_nxt;
  logic [31:0] mul_a_nxt, mul_b_nxt, add_a_nxt, add_b_nxt;
  logic [95:0] out_y_nxt;

  logic        coef_wr_s;
  logic [31:0] a00_s;
  logic [1:0]  col_inc_s;
  logic [1:0]  row_inc_s;

  // The bank only changes while no computation is in flight, so A is constant per vector.
  assign coef_wr_s = coef_we && (coef_addr < 4'd12) &&
                     ((state_r == S_IDLE) || (state_r == S_DONE));
  // A write coinciding with an accept must already be visible to the first product.
  assign a00_s     = (coef_we && (coef_addr == 4'd0)) ? coef_data : coef_r[0];
  assign col_inc_s = col_r + 2'd1;
  assign row_inc_s = row_r + 2'd1;

  // Coefficient bank: defaults on reset, writes accepted only when idle or done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 12; i++) coef_r[i] <= COEF_DEF[i];
    end else if (coef_wr_s) begin
      coef_r[coef_addr] <= coef_data;
    end
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_nxt     = state_r;
    x_nxt         = x_r;
    acc_nxt       = acc_r;
    y0_nxt        = y0_r;
    y1_nxt        = y1_r;
    row_nxt       = row_r;
    col_nxt       = col_r;
    phase_nxt     = phase_r;
    in_ready_nxt  = in_ready;
    out_valid_nxt = out_valid;
    busy_nxt      = busy;
    mul_a_nxt     = mul_a;
    mul_b_nxt     = mul_b;
    add_a_nxt     = add_a;
    add_b_nxt     = add_b;
    out_y_nxt     = out_y;
    case (state_r)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_nxt    = S_MUL;
          x_nxt[0]     = in_x[127:96];
          x_nxt[1]     = in_x[95:64];
          x_nxt[2]     = in_x[63:32];
          x_nxt[3]     = in_x[31:0];
          row_nxt      = 2'd0;
          col_nxt      = 2'd0;
          phase_nxt    = 8'd0;
          mul_a_nxt    = a00_s;
          mul_b_nxt    = in_x[127:96];
          in_ready_nxt = 1'b0;
          busy_nxt     = 1'b1;
        end else begin
          in_ready_nxt = 1'b1;
        end
      end
      S_MUL: begin
        if (phase_r == MUL_LAST) begin
          phase_nxt = 8'd0;
          if (col_r == 2'd0) begin
            // First product of a row seeds the accumulator; no add needed.
            acc_nxt   = mul_p;
            col_nxt   = 2'd1;
            mul_a_nxt = coef_r[{row_r, 2'd1}];
            mul_b_nxt = x_r[1];
          end else begin
            state_nxt = S_ADD;
            add_a_nxt = acc_r;
            add_b_nxt = mul_p;
          end
        end else begin
          phase_nxt = phase_r + 8'd1;
        end
      end
      S_ADD: begin
        if (phase_r == ADD_LAST) begin
          phase_nxt = 8'd0;
          acc_nxt   = add_s;
          if (col_r != 2'd3) begin
            state_nxt = S_MUL;
            col_nxt   = col_inc_s;
            mul_a_nxt = coef_r[{row_r, col_inc_s}];
            mul_b_nxt = x_r[col_inc_s];
          end else if (row_r != 2'd2) begin
            state_nxt = S_MUL;
            row_nxt   = row_inc_s;
            col_nxt   = 2'd0;
            mul_a_nxt = coef_r[{row_inc_s, 2'd0}];
            mul_b_nxt = x_r[0];
            if (row_r == 2'd0) begin
              y0_nxt = add_s;
            end else begin
              y1_nxt = add_s;
            end
          end else begin
            // The whole vector is published at once so a partial y is never visible.
            state_nxt     = S_DONE;
            out_valid_nxt = 1'b1;
            busy_nxt      = 1'b0;
            out_y_nxt     = {y0_r, y1_r, add_s};
          end
        end else begin
          phase_nxt = phase_r + 8'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt     = S_IDLE;
          out_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
        end else begin
          out_valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt     = S_IDLE;
        in_ready_nxt  = 1'b1;
        out_valid_nxt = 1'b0;
        busy_nxt      = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      for (int i = 0; i < 4; i++) x_r[i] <= 32'd0;
      acc_r     <= 32'd0;
      y0_r      <= 32'd0;
      y1_r      <= 32'd0;
      row_r     <= 2'd0;
      col_r     <= 2'd0;
      phase_r   <= 8'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      mul_a     <= 32'd0;
      mul_b     <= 32'd0;
      add_a     <= 32'd0;
      add_b     <= 32'd0;
      out_y     <= 96'd0;
    end else begin
      state_r   <= state_nxt;
      x_r       <= x_nxt;
      acc_r     <= acc_nxt;
      y0_r      <= y0_nxt;
      y1_r      <= y1_nxt;
      row_r     <= row_nxt;
      col_r     <= col_nxt;
      phase_r   <= phase_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
      mul_a     <= mul_a_nxt;
      mul_b     <= mul_b_nxt;
      add_a     <= add_a_nxt;
      add_b     <= add_b_nxt;
      out_y     <= out_y_nxt;
    end
  end

endmodule

// File: tb/tb_matvec_sequencer.sv
// Directed bench for matvec_sequencer: a default-latency instance plus a MUL_LAT=3/ADD_LAT=2
// instance, each fed by behavioural FP units that return X until operands have settled.
module tb_matvec_sequencer;

  localparam int ML1 = 1;
  localparam int AL1 = 1;
  localparam int ML2 = 3;
  localparam int AL2 = 2;
  localparam int N1  = 21;
  localparam int N2  = 54;

  localparam logic [127:0] V1  = 128'h40800000_40e00000_40c00000_00000000;
  localparam logic [127:0] V2  = 128'h3f800000_40000000_40400000_40800000;
  localparam logic [95:0]  Y1  = 96'hc1500000_40000000_41260000;
  localparam logic [95:0]  Y1A = 96'hc1300000_40000000_41260000;
  localparam logic [95:0]  Y1B = 96'hc1300000_40400000_41260000;
  localparam logic [95:0]  Y2  = 96'hc1040000_c0b00000_40b40000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_valid2, out_ready, out_ready2, coef_we;
  logic [127:0] in_x;
  logic [3:0]   coef_addr;
  logic [31:0]  coef_data;
  logic         in_ready, out_valid, busy, in_ready2, out_valid2, busy2;
  logic [95:0]  out_y, out_y2;
  logic [31:0]  mul_a, mul_b, mul_p, add_a, add_b, add_s;
  logic [31:0]  mul_a2, mul_b2, mul_p2, add_a2, add_b2, add_s2;

  int n_checks = 0;
  int n_fail   = 0;

  matvec_sequencer #(.MUL_LAT(ML1), .ADD_LAT(AL1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .add_a(add_a), .add_b(add_b), .add_s(add_s)
  );

  matvec_sequencer #(.MUL_LAT(ML2), .ADD_LAT(AL2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_x(in_x),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_y(out_y2),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy2),
    .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2), .add_a(add_a2), .add_b(add_b2), .add_s(add_s2)
  );

  function automatic real s2r(input logic [31:0] b);
    logic [10:0] e;
    logic [63:0] d;
    e = {3'b000, b[30:23]} + 11'd896;
    if (b[30:23] == 8'd0) d = {b[31], 63'd0};
    else                  d = {b[31], e, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Stability trackers: count negedges with unchanged operands since the last change.
  int m1_n = 0, a1_n = 0, m2_n = 0, a2_n = 0;
  logic [31:0] m1_sa, m1_sb, a1_sa, a1_sb, m2_sa, m2_sb, a2_sa, a2_sb;
  always @(negedge clk) begin
    m1_n <= (mul_a === m1_sa && mul_b === m1_sb)   ? ((m1_n < 1000) ? m1_n + 1 : m1_n) : 0;
    a1_n <= (add_a === a1_sa && add_b === a1_sb)   ? ((a1_n < 1000) ? a1_n + 1 : a1_n) : 0;
    m2_n <= (mul_a2 === m2_sa && mul_b2 === m2_sb) ? ((m2_n < 1000) ? m2_n + 1 : m2_n) : 0;
    a2_n <= (add_a2 === a2_sa && add_b2 === a2_sb) ? ((a2_n < 1000) ? a2_n + 1 : a2_n) : 0;
    m1_sa <= mul_a;  m1_sb <= mul_b;  a1_sa <= add_a;  a1_sb <= add_b;
    m2_sa <= mul_a2; m2_sb <= mul_b2; a2_sa <= add_a2; a2_sb <= add_b2;
  end

  always_comb begin
    mul_p  = (mul_a === m1_sa && mul_b === m1_sb && m1_n >= ML1 - 1) ?
             r2s(s2r(mul_a) * s2r(mul_b)) : 32'hxxxxxxxx;
    add_s  = (add_a === a1_sa && add_b === a1_sb && a1_n >= AL1 - 1) ?
             r2s(s2r(add_a) + s2r(add_b)) : 32'hxxxxxxxx;
    mul_p2 = (mul_a2 === m2_sa && mul_b2 === m2_sb && m2_n >= ML2 - 1) ?
             r2s(s2r(mul_a2) * s2r(mul_b2)) : 32'hxxxxxxxx;
    add_s2 = (add_a2 === a2_sa && add_b2 === a2_sb && a2_n >= AL2 - 1) ?
             r2s(s2r(add_a2) + s2r(add_b2)) : 32'hxxxxxxxx;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Offer x at a negedge; returns at the negedge after the accepting edge.
  task automatic start1(input logic [127:0] x);
    in_x     = x;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk1("accept_in_ready", in_ready, 1'b0);
    chk1("accept_busy", busy, 1'b1);
  endtask

  // Called k negedges after start1 returned; checks the exact edge out_valid rises.
  task automatic finish1(input int k, input logic [95:0] exp, input string tag);
    repeat (N1 - 1 - k) @(negedge clk);
    chk1({tag, "_valid_early"}, out_valid, 1'b0);
    @(negedge clk);
    chk1({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_y"}, 128'(out_y), 128'(exp));
    chk1({tag, "_busy_done"}, busy, 1'b0);
    chk1({tag, "_in_ready_done"}, in_ready, 1'b0);
  endtask

  task automatic release1();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk1("release_valid", out_valid, 1'b0);
    chk1("release_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b0; out_ready2 = 1'b0;
    in_x = 128'd0; coef_we = 1'b0; coef_addr = 4'd0; coef_data = 32'd0;
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_out_y", 128'(out_y), 128'd0);
    chk("rst_operands", 128'({mul_a, mul_b, add_a, add_b}), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Default bank, first vector, then stall in DONE.
    start1(V1);
    finish1(0, Y1, "v1");
    chk("done_mul_ops", 128'({mul_a, mul_b}), 128'({32'h3e800000, 32'h00000000}));
    chk("done_add_ops", 128'({add_a, add_b}), 128'({32'h41260000, 32'h00000000}));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("hold_valid", out_valid, 1'b1);
      chk("hold_y", 128'(out_y), 128'(Y1));
      chk1("hold_in_ready", in_ready, 1'b0);
    end
    chk("hold_mul_a", 128'(mul_a), 128'(32'h3e800000));
    release1();
    start1(V2);
    finish1(0, Y2, "v2");
    release1();

    // Coefficient write in IDLE.
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 32'h3f800000;
    @(negedge clk);
    coef_we = 1'b0;
    start1(V1);
    finish1(0, Y1A, "a00_write");
    release1();

    // Writes, out-of-range address, in_valid and in_x changes while busy are all ignored.
    start1(V1);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 32'h3f000000;
    in_valid = 1'b1; in_x = {4{32'h41000000}};
    chk1("busy_no_accept", in_ready, 1'b0);
    @(negedge clk);
    coef_addr = 4'd10; coef_data = 32'h00000000;
    @(negedge clk);
    coef_addr = 4'd13; coef_data = 32'h3f800000;
    chk1("busy_no_accept2", in_ready, 1'b0);
    @(negedge clk);
    coef_we = 1'b0; in_valid = 1'b0; in_x = 128'd0;
    finish1(4, Y1A, "busy_writes");
    release1();

    // Write in the accepting cycle is used by the accepted vector; earlier busy write stays dropped.
    coef_we = 1'b1; coef_addr = 4'd4; coef_data = 32'h3f800000;
    start1(V1);
    coef_we = 1'b0;
    finish1(0, Y1B, "accept_write");
    release1();

    // Reset during the first ADD of row 1.
    start1(V1);
    repeat (9) @(negedge clk);
    chk("row1_add_ops", 128'({add_a, add_b}), 128'({32'h40800000, 32'h40600000}));
    rst_n = 1'b0;
    #1;
    chk1("midrst_in_ready", in_ready, 1'b1);
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk("midrst_mul_a", 128'(mul_a), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start1(V1);
    finish1(0, Y1, "after_rst");
    release1();

    // Long-latency instance.
    in_x = V1; in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    chk1("lat_in_ready", in_ready2, 1'b0);
    chk1("lat_busy", busy2, 1'b1);
    repeat (N2 - 1) @(negedge clk);
    chk1("lat_valid_early", out_valid2, 1'b0);
    @(negedge clk);
    chk1("lat_valid", out_valid2, 1'b1);
    chk("lat_y", 128'(out_y2), 128'(Y1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
